seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Transmit end of the multiplexed 7-segment display interface; the display decoder consumes its outputs.
- Holds four hex digits with per-digit decimal point and blank controls.
- Time-multiplexes them onto one shared segment bus (SegA..SegG, DP) with an active-low one-hot digit select nDigit.
- Applies prescaled scanning, inter-digit dead time, tear-free frame-synchronous updates and optional leading-zero suppression.

Parameters:
SCAN_DIV, 256, clocks per digit slot; legal range >= 2.
BLANK_CYCLES, 4, dead-time clocks at the start of each slot; legal range 0 <= BLANK_CYCLES < SCAN_DIV.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
Load  in  1  capture strobe for Value/DPIn/BlankIn/LZS; sampled each rising edge.
Value  in  16  four hex digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
DPIn  in  4  decimal point per digit; bit n = digit n.
BlankIn  in  4  force digit n dark, both segments and DP.
LZS  in  1  leading-zero suppression enable.
Pending  out  1  shadow data captured but not yet applied.
FrameStart  out  1  one-cycle pulse at the start of each frame.
SegA, SegB, SegC, SegD, SegE, SegF, SegG  out  1 each  segment drives, active-high.
DP  out  1  decimal point drive, active-high.
nDigit  out  4  digit select, active-low one-hot: 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3; 1111=none.

Behaviour:
- Clock and reset: single clock domain named Clock; reset named Reset, asynchronous and active-high.
- Reset state:
  - nDigit=1111; all Seg outputs, DP, Pending and FrameStart are 0.
  - Prescaler p=0, slot s=0.
  - Shadow and active registers: Value=0, DP=0, LZS=0, Blank=1111 (display stays dark until the first apply).
- Counters:
  - p counts 0..SCAN_DIV-1 and wraps; on wrap, s advances 0->1->2->3->0.
  - Frame boundary edge = the edge where s=3 and p=SCAN_DIV-1.
  - Frame length = 4*SCAN_DIV clocks.
- Outputs (Seg*, DP, nDigit, FrameStart) are registered from the current (s,p) state and active registers: 1-cycle latency.
  - p < BLANK_CYCLES: nDigit=1111, segments=0, DP=0 (dead time).
  - Otherwise: nDigit selects digit s; segments = hex decode of active digit s; DP = active DP[s].
  - FrameStart=1 in the cycle after state (s=0, p=0), including the first such state after reset.
- Hex decode (lit segments):
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg
- Blanking:
  - Blank[n]=1: digit n segments and DP are 0; nDigit still asserts in its slot.
  - LZS=1: digit3 is suppressed if its value is 0. Digit2 is suppressed if its value is 0 and digit3 is suppressed. Digit1 follows the same rule relative to digit2. Digit0 is never suppressed.
  - A suppressed digit has segments=0, but its DP is still driven from DP[n].
- Load handshake:
  - Load=1 at an edge copies Value/DPIn/BlankIn/LZS into shadow; Pending=1 from the next cycle.
  - Repeated Loads before the boundary overwrite the shadow (last wins).
  - At the boundary edge, shadow -> active and Pending -> 0.
  - Load on the boundary edge itself: the inputs bypass directly into active (and shadow); Pending stays 0.
  - Load never alters the counters.
- Reset mid-operation: outputs go dark immediately (asynchronously), counters return to 0, and any pending data is discarded.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset held 3 cycles, then released with no Load -> nDigit stays 1111 except scan slots, where nDigit asserts with Seg=0 and DP=0; Pending=0; FrameStart pulses every 32 clocks.
2. Load Value=16'h1234, DPIn=4'b0100 mid-frame:
   - Pending=1 until the boundary, then 0.
   - Next frame: slot0 nDigit=1110 shows 4 (bcfg).
   - slot2 nDigit=1011 shows 2 (abdeg) with DP=1.
   - slot3 nDigit=0111 shows 1 (bc).
3. Dead time -> in every slot, the first 2 output cycles have nDigit=1111 and all segments 0; the following 6 cycles show the digit.
4. LZS=1, Value=16'h0040 -> digits 3 and 2 segments=0; digit1 shows 4; digit0 shows 0 (abcdef). With Value=16'h0400, digit1 shows 0.
5. Two Loads mid-frame (16'hAAAA, then 16'h5555) -> 5555 is displayed after the boundary. Load 16'hFFFF on the boundary edge -> F displayed in the next frame and Pending never rises.
6. Reset pulsed mid-slot2 with Pending=1 -> outputs dark immediately, Pending=0, and the next FrameStart occurs 1 cycle after reset release.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver.
// Scans digits 0..3 in SCAN_DIV-clock slots. Each slot starts with BLANK_CYCLES
// clocks of dead time. New data is staged in a shadow copy and promoted to the
// active copy only at a frame boundary, so a frame never mixes old and new data.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 256,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic [3:0]  DPIn,
  input  logic [3:0]  BlankIn,
  input  logic        LZS,
  output logic        Pending,
  output logic        FrameStart,
  output logic        SegA,
  output logic        SegB,
  output logic        SegC,
  output logic        SegD,
  output logic        SegE,
  output logic        SegF,
  output logic        SegG,
  output logic        DP,
  output logic [3:0]  nDigit
);

  localparam int              PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   P_BLANK = PW'(BLANK_CYCLES);
  // Packed display record: {lzs, blank[3:0], dp[3:0], value[15:0]}.
  // The reset value keeps every digit blanked until the first apply.
  localparam logic [24:0]     DATA_RST = {1'b0, 4'hF, 4'h0, 16'h0000};

  logic [PW-1:0] p_q, p_d;
  logic [1:0]    s_q, s_d;
  logic [24:0]   sh_q, sh_d, act_q, act_d;
  logic          pend_q, pend_d;
  logic [3:0]    nd_q, nd_d;
  logic [6:0]    seg_q, seg_d;   // {g,f,e,d,c,b,a}
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic [24:0]   in_pkt;
  logic          boundary;
  logic [15:0]   act_val;
  logic [3:0]    act_dp, act_blk, sup, digit;
  logic          act_lzs;

  assign in_pkt  = {LZS, BlankIn, DPIn, Value};
  assign act_val = act_q[15:0];
  assign act_dp  = act_q[19:16];
  assign act_blk = act_q[23:20];
  assign act_lzs = act_q[24];
  assign digit   = act_val[{s_q, 2'b00} +: 4];

  function automatic logic [6:0] hex_dec(input logic [3:0] h);
    logic [6:0] r;
    case (h)
      4'h0: r = 7'h3F;  4'h1: r = 7'h06;  4'h2: r = 7'h5B;  4'h3: r = 7'h4F;
      4'h4: r = 7'h66;  4'h5: r = 7'h6D;  4'h6: r = 7'h7D;  4'h7: r = 7'h07;
      4'h8: r = 7'h7F;  4'h9: r = 7'h6F;  4'hA: r = 7'h77;  4'hB: r = 7'h7C;
      4'hC: r = 7'h39;  4'hD: r = 7'h5E;  4'hE: r = 7'h79;  default: r = 7'h71;
    endcase
    return r;
  endfunction

  // Leading-zero suppression chain: a digit is suppressed only when it is zero
  // and every digit to its left is suppressed; digit 0 always shows.
  always_comb begin
    sup    = '0;
    sup[3] = act_lzs & (act_val[15:12] == 4'h0);
    sup[2] = sup[3]  & (act_val[11:8]  == 4'h0);
    sup[1] = sup[2]  & (act_val[7:4]   == 4'h0);
  end

  // Prescaler/slot counters and shadow/active data handoff.
  always_comb begin
    boundary = (s_q == 2'd3) && (p_q == P_LAST);
    p_d      = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    s_d      = (p_q == P_LAST) ? s_q + 2'd1 : s_q;
    sh_d     = Load ? in_pkt : sh_q;
    act_d    = act_q;
    pend_d   = pend_q | Load;
    if (boundary) begin
      // A load coinciding with the boundary goes straight to the display.
      act_d  = Load ? in_pkt : sh_q;
      pend_d = 1'b0;
    end
  end

  // Registered display outputs derived from the current slot position.
  always_comb begin
    nd_d  = 4'hF;
    seg_d = '0;
    dp_d  = 1'b0;
    fs_d  = (s_q == 2'd0) && (p_q == '0);
    if (p_q >= P_BLANK) begin
      nd_d = ~(4'b0001 << s_q);
      if (!act_blk[s_q]) begin
        dp_d = act_dp[s_q];
        if (!sup[s_q]) seg_d = hex_dec(digit);
      end
    end
  end

  // State registers; reset darkens the display immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      p_q    <= '0;
      s_q    <= '0;
      sh_q   <= DATA_RST;
      act_q  <= DATA_RST;
      pend_q <= 1'b0;
      nd_q   <= 4'hF;
      seg_q  <= '0;
      dp_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      p_q    <= p_d;
      s_q    <= s_d;
      sh_q   <= sh_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      nd_q   <= nd_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign Pending    = pend_q;
  assign FrameStart = fs_q;
  assign nDigit     = nd_q;
  assign DP         = dp_q;
  assign SegA       = seg_q[0];
  assign SegB       = seg_q[1];
  assign SegC       = seg_q[2];
  assign SegD       = seg_q[3];
  assign SegE       = seg_q[4];
  assign SegF       = seg_q[5];
  assign SegG       = seg_q[6];

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a frame-time reference model.
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Load  = 1'b0;
  logic [15:0] Value = '0;
  logic [3:0]  DPIn  = '0;
  logic [3:0]  BlankIn = '0;
  logic        LZS   = 1'b0;
  logic        Pending, FrameStart, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP;
  logic [3:0]  nDigit;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .Value(Value), .DPIn(DPIn),
    .BlankIn(BlankIn), .LZS(LZS), .Pending(Pending), .FrameStart(FrameStart),
    .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE),
    .SegF(SegF), .SegG(SegG), .DP(DP), .nDigit(nDigit)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  string HEXSEG [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    string      str;
    logic [6:0] r;
    r   = '0;
    str = HEXSEG[h];
    for (int i = 0; i < str.len(); i++) r[str[i] - 8'h61] = 1'b1;
    return r;
  endfunction

  int          m_t, m_s, m_p;
  logic [15:0] ma_val, ms_val;
  logic [3:0]  ma_dp, ms_dp, ma_blk, ms_blk;
  logic        ma_lzs, ms_lzs, m_pend, m_sup;
  logic [3:0]  exp_nd;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fs;

  // Position is derived from elapsed clocks since reset; data follows the
  // load/apply rules, and outputs appear one edge after the state they show.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_t = 0;
      ma_val = '0; ms_val = '0; ma_dp = '0; ms_dp = '0;
      ma_blk = 4'hF; ms_blk = 4'hF; ma_lzs = 1'b0; ms_lzs = 1'b0; m_pend = 1'b0;
      exp_nd = 4'hF; exp_seg = '0; exp_dp = 1'b0; exp_fs = 1'b0;
    end else begin
      m_s = (m_t / SD) % 4;
      m_p = m_t % SD;
      exp_fs = (m_t % FR) == 0;
      exp_nd = 4'hF; exp_seg = '0; exp_dp = 1'b0;
      if (m_p >= BC) begin
        exp_nd = 4'hF; exp_nd[m_s] = 1'b0;
        m_sup = ma_lzs && (m_s > 0);
        for (int k = m_s; k < 4; k++) if (ma_val[4*k +: 4] != 4'h0) m_sup = 1'b0;
        if (!ma_blk[m_s]) begin
          exp_dp = ma_dp[m_s];
          if (!m_sup) exp_seg = seg_of(ma_val[4*m_s +: 4]);
        end
      end
      if (Load) begin
        ms_val = Value; ms_dp = DPIn; ms_blk = BlankIn; ms_lzs = LZS;
      end
      if ((m_t % FR) == FR - 1) begin
        ma_val = ms_val; ma_dp = ms_dp; ma_blk = ms_blk; ma_lzs = ms_lzs;
        m_pend = 1'b0;
      end else if (Load) begin
        m_pend = 1'b1;
      end
      m_t++;
    end
  end

  logic [13:0] obs, expv;
  assign obs  = {nDigit, SegG, SegF, SegE, SegD, SegC, SegB, SegA, DP, FrameStart, Pending};
  assign expv = {exp_nd, exp_seg, exp_dp, exp_fs, m_pend};

  logic [6:0] seg_now;
  assign seg_now = {SegG, SegF, SegE, SegD, SegC, SegB, SegA};

  // ---------------- tests ----------------
  task automatic test_reset();
    int fs_cnt, lit, bad;
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      n_tests++;
      if (obs !== {4'hF, 10'h0}) begin
        n_fail++; $display("FAIL reset_hold: got %h want %h", obs, {4'hF, 10'h0});
      end
    end
    Reset = 1'b0;
    fs_cnt = 0; lit = 0; bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      n_tests++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL idle_scan t=%0d: got %h want %h", i, obs, expv);
      end
      if (FrameStart) fs_cnt++;
      if (nDigit != 4'hF) lit++;
      if (nDigit != 4'hF && (seg_now != 0 || DP)) bad++;
    end
    n_tests++;
    if (fs_cnt !== 3) begin n_fail++; $display("FAIL idle_fs_count: got %0d want 3", fs_cnt); end
    n_tests++;
    if (lit !== 60) begin n_fail++; $display("FAIL idle_select_count: got %0d want 60", lit); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL idle_dark_segments: got %0d want 0", bad); end
  endtask

  task automatic test_load_1234();
    bit got;
    repeat ($urandom_range(3, 10)) @(negedge Clock);
    Load = 1'b1; Value = 16'h1234; DPIn = 4'b0100; BlankIn = 4'h0; LZS = 1'b0;
    @(negedge Clock);
    Load = 1'b0;
    n_tests++;
    if (Pending !== 1'b1) begin n_fail++; $display("FAIL load_pending: got %b want 1", Pending); end
    got = 0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      @(negedge Clock);
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL load_wait: got %h want %h", obs, expv); end
      if (FrameStart) got = 1;
    end
    n_tests++;
    if (!got || Pending !== 1'b0) begin
      n_fail++; $display("FAIL load_apply: got fs=%b pend=%b want fs=1 pend=0", got, Pending);
    end
    for (int k = 1; k < FR; k++) begin
      @(negedge Clock);
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL load_frame k=%0d: got %h want %h", k, obs, expv); end
      if (k == 4 || k == 20 || k == 28) begin
        n_tests++;
        if (k == 4 && {nDigit, seg_now, DP} !== {4'b1110, 7'h66, 1'b0}) begin
          n_fail++; $display("FAIL slot0_shows4: got %b %h %b", nDigit, seg_now, DP);
        end
        if (k == 20 && {nDigit, seg_now, DP} !== {4'b1011, 7'h5B, 1'b1}) begin
          n_fail++; $display("FAIL slot2_shows2dp: got %b %h %b", nDigit, seg_now, DP);
        end
        if (k == 28 && {nDigit, seg_now, DP} !== {4'b0111, 7'h06, 1'b0}) begin
          n_fail++; $display("FAIL slot3_shows1: got %b %h %b", nDigit, seg_now, DP);
        end
      end
    end
  endtask

  task automatic test_dead_time();
    bit got;
    logic [3:0] want_nd;
    got = 0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      @(negedge Clock);
      if (FrameStart) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL dead_sync: got no FrameStart want one"); end
    for (int k = 0; k < FR; k++) begin
      want_nd = 4'hF;
      if (k % SD >= BC) want_nd[k / SD] = 1'b0;
      n_tests++;
      if (nDigit !== want_nd || (k % SD < BC && (seg_now !== 7'h0 || DP !== 1'b0))) begin
        n_fail++; $display("FAIL dead_time k=%0d: got %b %h want %b", k, nDigit, seg_now, want_nd);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_lzs();
    logic [15:0] vals [2] = '{16'h0040, 16'h0400};
    logic [6:0]  want [2][4] = '{'{7'h3F, 7'h66, 7'h00, 7'h00}, '{7'h3F, 7'h3F, 7'h66, 7'h00}};
    bit got;
    for (int v = 0; v < 2; v++) begin
      @(negedge Clock);
      Load = 1'b1; Value = vals[v]; DPIn = 4'h0; BlankIn = 4'h0; LZS = 1'b1;
      @(negedge Clock);
      Load = 1'b0;
      got = 0;
      for (int i = 0; i < 2 * FR && !got; i++) begin
        @(negedge Clock);
        if (FrameStart) got = 1;
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL lzs_sync: got no FrameStart want one"); end
      for (int k = 1; k < FR; k++) begin
        @(negedge Clock);
        n_tests++;
        if (obs !== expv) begin n_fail++; $display("FAIL lzs_frame k=%0d: got %h want %h", k, obs, expv); end
        if (k % SD == 4) begin
          n_tests++;
          if (seg_now !== want[v][k / SD]) begin
            n_fail++; $display("FAIL lzs_digit%0d val=%h: got %h want %h", k / SD, vals[v], seg_now, want[v][k / SD]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit got, rose;
    LZS = 1'b0; DPIn = 4'h0; BlankIn = 4'h0;
    @(negedge Clock); Load = 1'b1; Value = 16'hAAAA;
    @(negedge Clock); Load = 1'b0;
    @(negedge Clock); Load = 1'b1; Value = 16'h5555;
    @(negedge Clock); Load = 1'b0;
    got = 0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      @(negedge Clock);
      if (FrameStart) got = 1;
    end
    repeat (4) @(negedge Clock);
    n_tests++;
    if (!got || seg_now !== 7'h6D || nDigit !== 4'b1110) begin
      n_fail++; $display("FAIL last_load_wins: got %h %b want 6d 1110", seg_now, nDigit);
    end
    // align so the next active edge is the frame boundary
    got = 0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      if ((m_t % FR) == FR - 1) got = 1;
      else @(negedge Clock);
    end
    Load = 1'b1; Value = 16'hFFFF;
    @(negedge Clock);
    Load = 1'b0;
    rose = 0;
    for (int k = 0; k < FR; k++) begin
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL bypass_frame k=%0d: got %h want %h", k, obs, expv); end
      if (Pending) rose = 1;
      if (k == 12) begin
        n_tests++;
        if (seg_now !== 7'h71 || FrameStart !== 1'b0) begin
          n_fail++; $display("FAIL bypass_shows_f: got %h want 71", seg_now);
        end
      end
      @(negedge Clock);
    end
    n_tests++;
    if (rose) begin n_fail++; $display("FAIL bypass_pending: got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      @(negedge Clock);
      if (FrameStart) got = 1;
    end
    @(negedge Clock);
    Load = 1'b1; Value = 16'h9876; DPIn = 4'hF;
    @(negedge Clock);
    Load = 1'b0;
    repeat (18) @(negedge Clock);
    n_tests++;
    if (Pending !== 1'b1 || nDigit !== 4'b1011) begin
      n_fail++; $display("FAIL mid_pre: got pend=%b nd=%b want 1 1011", Pending, nDigit);
    end
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== {4'hF, 10'h0}) begin n_fail++; $display("FAIL mid_async_dark: got %h want %h", obs, {4'hF, 10'h0}); end
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    n_tests++;
    if (FrameStart !== 1'b1 || Pending !== 1'b0) begin
      n_fail++; $display("FAIL mid_first_fs: got fs=%b pend=%b want 1 0", FrameStart, Pending);
    end
    for (int k = 1; k < 2 * FR; k++) begin
      @(negedge Clock);
      n_tests++;
      if (obs !== expv || seg_now !== 7'h0) begin
        n_fail++; $display("FAIL mid_discard k=%0d: got %h want %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL random i=%0d: got %h want %h", i, obs, expv); end
      Load = ($urandom_range(0, 5) == 0);
      for (int d = 0; d < 4; d++) v[4*d +: 4] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      Value   = v;
      DPIn    = 4'($urandom);
      BlankIn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      LZS     = 1'($urandom);
    end
    Load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_dead_time();
    test_lzs();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
